div_unit: RTL and testbench



---
 rtl/div_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_div_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit -- iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Sits in the execute stage. An accepted start either resolves on the fast
// path (divide by zero, signed overflow, optional cache hit) and presents
// the result one cycle later, or iterates one quotient bit per cycle and
// presents the result XLEN+1 cycles after accept. stall_req holds the
// upstream pipeline while the divider is working.
//
// Ports:
//   clk        core clock
//   rst_n      asynchronous active-low reset
//   start      decoded div_inst qualified by the ID/EX valid bit
//   divsel     001 DIV, 010 DIVU, 011 REM, 100 REMU (other codes ignored)
//   op_a       dividend (rs1)
//   op_b       divisor (rs2)
//   flush      pipeline flush, aborts an operation in CALC
//   busy       high whenever the FSM is not idle
//   stall_req  freeze request to upstream stages
//   done       one-cycle pulse, result valid
//   result     quotient or remainder, held until the next accepted result
//
// Optional build macro:
//   DIV_RESULT_CACHE_EN  remembers the last normal-path operands with both
//                        quotient and remainder; a matching DIV/REM or
//                        DIVU/REMU request completes on the fast path.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | waiting for work
// CALC  | iterating, one restoring step per cycle
// DONE  | presenting the result (done pulse)

module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      divsel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // latched operation context
  logic            rem_sel;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dsr;
  logic [XLEN-1:0] rem_q;
  logic [CW-1:0]   cnt;

  // request decode
  logic            sel_valid;
  logic            op_signed;
  logic            op_rem;
  logic            accept;
  logic            sign_a_in;
  logic            sign_b_in;
  logic [XLEN-1:0] mag_a_in;
  logic [XLEN-1:0] mag_b_in;
  logic            div_zero;
  logic            ovf;
  logic            cache_hit;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  // restoring step
  logic [XLEN-1:0] rem_sh;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] dvd_step;
  logic            last_step;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] calc_res;

  assign sel_valid = (divsel == 3'b001) || (divsel == 3'b010) ||
                     (divsel == 3'b011) || (divsel == 3'b100);
  assign op_signed = (divsel == 3'b001) || (divsel == 3'b011);
  assign op_rem    = (divsel == 3'b011) || (divsel == 3'b100);

  assign accept = start && (state == IDLE) && sel_valid && !flush;

  assign sign_a_in = op_signed & op_a[XLEN-1];
  assign sign_b_in = op_signed & op_b[XLEN-1];
  assign mag_a_in  = sign_a_in ? (~op_a + 1'b1) : op_a;
  assign mag_b_in  = sign_b_in ? (~op_b + 1'b1) : op_b;

  assign div_zero = (op_b == '0);
  assign ovf      = op_signed && (op_a == SMIN) && (op_b == '1);

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_valid;
  logic            cache_signed;
  logic [XLEN-1:0] cache_a;
  logic [XLEN-1:0] cache_b;
  logic [XLEN-1:0] cache_q;
  logic [XLEN-1:0] cache_r;
  logic            lat_signed;
  logic [XLEN-1:0] lat_a;
  logic [XLEN-1:0] lat_b;

  // signedness match alone pairs DIV with REM and DIVU with REMU
  assign cache_hit = cache_valid && (cache_signed == op_signed) &&
                     (cache_a == op_a) && (cache_b == op_b);
`else
  assign cache_hit = 1'b0;
`endif

  assign fast = div_zero | ovf | cache_hit;

  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = op_rem ? op_a : '1;
    end else if (ovf) begin
      fast_res = op_rem ? '0 : SMIN;
`ifdef DIV_RESULT_CACHE_EN
    end else if (cache_hit) begin
      fast_res = op_rem ? cache_r : cache_q;
`endif
    end
  end

  // The remainder never exceeds 2^k-1 after k steps, so dropping its top bit
  // on the shift cannot lose information before the final step.
  assign rem_sh    = {rem_q[XLEN-2:0], dvd[XLEN-1]};
  assign diff      = {1'b0, rem_sh} - {1'b0, dsr};
  assign q_bit     = ~diff[XLEN];
  assign rem_step  = q_bit ? diff[XLEN-1:0] : rem_sh;
  assign dvd_step  = {dvd[XLEN-2:0], q_bit};
  assign last_step = (cnt == CW'(1));

  // sign_b is only ever set for signed ops, so unsigned ops pass through
  assign quo_fix  = (sign_a ^ sign_b) ? (~dvd_step + 1'b1) : dvd_step;
  assign rem_fix  = sign_a ? (~rem_step + 1'b1) : rem_step;
  assign calc_res = rem_sel ? rem_fix : quo_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    // flush drops the CALC term combinationally so the front end can redirect
    stall_req = accept || ((state == CALC) && !flush);
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = fast ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_sel <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      dvd     <= '0;
      dsr     <= '0;
      rem_q   <= '0;
      cnt     <= '0;
      result  <= '0;
    end else if (accept) begin
      rem_sel <= op_rem;
      sign_a  <= sign_a_in;
      sign_b  <= sign_b_in;
      dvd     <= mag_a_in;
      dsr     <= mag_b_in;
      rem_q   <= '0;
      cnt     <= CW'(XLEN);
      if (fast) begin
        result <= fast_res;
      end
    end else if ((state == CALC) && !flush) begin
      dvd   <= dvd_step;
      rem_q <= rem_step;
      cnt   <= cnt - CW'(1);
      if (last_step) begin
        result <= calc_res;
      end
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  // flush leaves the cache alone; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_q      <= '0;
      cache_r      <= '0;
      lat_signed   <= 1'b0;
      lat_a        <= '0;
      lat_b        <= '0;
    end else begin
      if (accept) begin
        lat_signed <= op_signed;
        lat_a      <= op_a;
        lat_b      <= op_b;
      end
      if ((state == CALC) && !flush && last_step) begin
        cache_valid  <= 1'b1;
        cache_signed <= lat_signed;
        cache_a      <= lat_a;
        cache_b      <= lat_b;
        cache_q      <= quo_fix;
        cache_r      <= rem_fix;
      end
    end
  end
`endif

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  divsel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  // reference-model state
  bit          c_valid  = 1'b0;
  bit          c_signed = 1'b0;
  logic [31:0] c_a = '0;
  logic [31:0] c_b = '0;
  logic [31:0] last_exp = '0;

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .divsel    (divsel),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_signed_sel(input logic [2:0] sel);
    return (sel == 3'd1) || (sel == 3'd3);
  endfunction

  // RISC-V M-extension semantics from plain integer arithmetic
  function automatic logic [31:0] ref_val(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (sel)
      3'd1: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd2: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd3: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    bit f;
    f = (b == 0) || (is_signed_sel(sel) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_RESULT_CACHE_EN
    f = f || (c_valid && c_a == a && c_b == b && c_signed == is_signed_sel(sel));
`endif
    return f;
  endfunction

  task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    bit          fast;
    int          exp_lat;
    int          lat;
    int          stall_cnt;
    int          busy_cnt;
    bit          seen;
    exp       = ref_val(sel, a, b);
    fast      = is_fast(sel, a, b);
    exp_lat   = fast ? 1 : 33;
    @(negedge clk);
    start  = 1'b1;
    divsel = sel;
    op_a   = a;
    op_b   = b;
    #1;
    check_val({tag, "_acc_stall"}, 32'(stall_req), 32'd1);
    lat       = 0;
    stall_cnt = 1;
    busy_cnt  = 0;
    seen      = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      lat++;
      if (busy) busy_cnt++;
      if (stall_req) stall_cnt++;
      if (done) seen = 1'b1;
    end
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_result"}, result, exp);
    check_val({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
    check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    if (!fast) begin
      c_valid  = 1'b1;
      c_a      = a;
      c_b      = b;
      c_signed = is_signed_sel(sel);
    end
    last_exp = exp;
    @(negedge clk);
    #1;
    check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
    check_val({tag, "_hold"}, result, exp);
  endtask

  initial begin
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pa;
    logic [31:0] pb;
    int          mode;
    rst_n  = 1'b0;
    start  = 1'b0;
    divsel = 3'd0;
    op_a   = '0;
    op_b   = '0;
    flush  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_stall", 32'(stall_req), 32'd0);
    check_val("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd1, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, "rem_neg7_2");
    run_op(3'd2, 32'd100, 32'd7, "divu_100_7");
    run_op(3'd4, 32'd100, 32'd7, "remu_100_7");
    run_op(3'd1, 32'd5, 32'd0, "div_5_0");
    run_op(3'd4, 32'd5, 32'd0, "remu_5_0");
    run_op(3'd2, 32'd0, 32'd0, "divu_0_0");
    run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(3'd1, 32'd100, 32'd7, "div_100_7");
    run_op(3'd3, 32'd100, 32'd7, "rem_100_7");
    run_op(3'd2, 32'd100, 32'd7, "divu_100_7b");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "divu_big");
    run_op(3'd4, 32'hFFFF_FFFF, 32'h8000_0001, "remu_big");

    // flush mid-CALC, with an ignored start inside CALC
    @(negedge clk);
    start  = 1'b1;
    divsel = 3'd2;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(negedge clk);
    start  = 1'b1;
    divsel = 3'd1;
    op_a   = 32'd5;
    op_b   = 32'd0;
    #1;
    check_val("calc_start_stall", 32'(stall_req), 32'd1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check_val("calc_start_ignored", 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    #1;
    check_val("flush_stall", 32'(stall_req), 32'd0);
    check_val("flush_busy_cur", 32'(busy), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_val("flush_busy", 32'(busy), 32'd0);
    check_val("flush_done", 32'(done), 32'd0);
    check_val("flush_result", result, last_exp);
    repeat (30) @(negedge clk);
    #1;
    check_val("flush_no_late_done", 32'(done), 32'd0);
    run_op(3'd2, 32'd9, 32'd3, "divu_9_3");

    // invalid selects
    for (int s = 0; s < 8; s++) begin
      if (s == 0 || s > 4) begin
        @(negedge clk);
        start  = 1'b1;
        divsel = 3'(s);
        op_a   = 32'd20;
        op_b   = 32'd4;
        #1;
        check_val($sformatf("badsel%0d_stall", s), 32'(stall_req), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check_val($sformatf("badsel%0d_busy", s), 32'(busy), 32'd0);
      end
    end

    // start together with flush is ignored
    @(negedge clk);
    start  = 1'b1;
    flush  = 1'b1;
    divsel = 3'd2;
    op_a   = 32'd9;
    op_b   = 32'd3;
    #1;
    check_val("start_flush_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1;
    check_val("start_flush_busy", 32'(busy), 32'd0);

    // flush during DONE still lets done pulse
    @(negedge clk);
    start  = 1'b1;
    divsel = 3'd1;
    op_a   = 32'd5;
    op_b   = 32'd0;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    #1;
    check_val("flush_in_done_done", 32'(done), 32'd1);
    check_val("flush_in_done_result", result, 32'hFFFF_FFFF);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_val("flush_in_done_after", 32'(done), 32'd0);
    last_exp = 32'hFFFF_FFFF;

    // reset mid-CALC
    @(negedge clk);
    start  = 1'b1;
    divsel = 3'd1;
    op_a   = 32'd1234;
    op_b   = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_done", 32'(done), 32'd0);
    check_val("midrst_stall", 32'(stall_req), 32'd0);
    check_val("midrst_result", result, 32'd0);
    c_valid  = 1'b0;
    last_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd3, 32'd100, 32'd7, "rem_after_rst");

    // randomized operations
    pa = 32'd77;
    pb = 32'd5;
    for (int i = 0; i < 40; i++) begin
      sel  = 3'($urandom_range(1, 4));
      mode = $urandom_range(0, 9);
      case (mode)
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = pa; b = pb; end
        3: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        4: begin a = -32'($urandom_range(1, 200)); b = $urandom_range(1, 20); end
        5: begin a = $urandom_range(0, 200); b = -32'($urandom_range(1, 20)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op(sel, a, b, $sformatf("rnd%0d", i));
      pa = a;
      pb = b;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
